multiword_adder_sequencer: RTL and testbench



---
 rtl/multiword_adder_sequencer_if.sv | 33 +++
 rtl/multiword_adder_sequencer.sv | 151 +++++++++++++++
 tb/tb_multiword_adder_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multiword_adder_sequencer_if.sv
// Handshake bus for multiword_adder_sequencer.
// Operand side: IN_VALID/IN_READY with A, B, C_IN (and SUB when MWADD_SUB_EN is defined).
// Result side: OUT_VALID/OUT_READY with R, C_OUT.
// master = producer/consumer (testbench or parent), slave = sequencer.
interface multiword_adder_sequencer_if #(
  parameter int unsigned word_width = 8,
  parameter int unsigned word_count = 4
);
  localparam int unsigned W = word_width * word_count;

  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_IN;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] R;
  logic         C_OUT;
`ifdef MWADD_SUB_EN
  logic         SUB;

  modport master (output IN_VALID, A, B, C_IN, SUB, OUT_READY,
                  input  IN_READY, OUT_VALID, R, C_OUT);
  modport slave  (input  IN_VALID, A, B, C_IN, SUB, OUT_READY,
                  output IN_READY, OUT_VALID, R, C_OUT);
`else
  modport master (output IN_VALID, A, B, C_IN, OUT_READY,
                  input  IN_READY, OUT_VALID, R, C_OUT);
  modport slave  (input  IN_VALID, A, B, C_IN, OUT_READY,
                  output IN_READY, OUT_VALID, R, C_OUT);
`endif
endinterface

// File: rtl/multiword_adder_sequencer.sv
// Multi-cycle wide adder: adds word_count x word_width operands one word per clock,
// LSW first, through a single word_width look-ahead adder with a registered carry.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - slave side of multiword_adder_sequencer_if (operand and result handshakes)
// Optional feature: define MWADD_SUB_EN to add the SUB input (A - B via inverted B, carry-in 1).
module multiword_adder_sequencer #(
  parameter int unsigned cascade_size = 4,
  parameter int unsigned word_width   = 8,
  parameter int unsigned word_count   = 4
) (
  input  logic CLK,
  input  logic RST,
  multiword_adder_sequencer_if.slave bus
);
  localparam int unsigned W    = word_width * word_count;
  localparam int unsigned IDXW = (word_count > 1) ? $clog2(word_count) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(word_count - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            cy;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    r;
  logic            c_out;
  logic            out_valid;
  logic            sub_q;
  logic            accept_carry;

  logic [word_width-1:0] word_a;
  logic [word_width-1:0] word_b;
  logic [word_width-1:0] sum;
  logic                  co;
  logic                  in_ready_c;

  // Operand side is free in IDLE, or in HOLD when the result leaves this same cycle.
  assign in_ready_c = (state == IDLE) || ((state == HOLD) && bus.OUT_READY);

  assign bus.IN_READY  = in_ready_c;
  assign bus.OUT_VALID = out_valid;
  assign bus.R         = r;
  assign bus.C_OUT     = c_out;

`ifdef MWADD_SUB_EN
  // Subtraction starts with carry 1 so that ~B + 1 forms the two's complement.
  assign accept_carry = bus.SUB ? 1'b1 : bus.C_IN;
`else
  assign accept_carry = bus.C_IN;
`endif

  // Current word of each operand; B is inverted for subtraction.
  assign word_a = op_a[32'(idx) * word_width +: word_width];
  assign word_b = sub_q ? ~op_b[32'(idx) * word_width +: word_width]
                        :  op_b[32'(idx) * word_width +: word_width];

  // fast_adder: ripple inside each cascade_size group, group carry-out from
  // the group generate/propagate terms so carries skip across groups.
  always_comb begin : fast_adder
    logic [word_width-1:0] g;
    logic [word_width-1:0] p;
    logic [word_width:0]   cv;
    logic                  grp_g;
    logic                  grp_p;
    g     = word_a & word_b;
    p     = word_a ^ word_b;
    cv    = '0;
    cv[0] = cy;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int unsigned k = 0; k < word_width; k++) begin
      if ((k % cascade_size) == 0) begin
        grp_g = 1'b0;
        grp_p = 1'b1;
      end
      cv[k+1] = g[k] | (p[k] & cv[k]);
      grp_g   = g[k] | (p[k] & grp_g);
      grp_p   = grp_p & p[k];
      if (((k % cascade_size) == (cascade_size - 1)) || (k == (word_width - 1))) begin
        cv[k+1] = grp_g | (grp_p & cv[k - (k % cascade_size)]);
      end
    end
    sum = p ^ cv[word_width-1:0];
    co  = cv[word_width];
  end

  // Sequencer FSM with registered result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      cy        <= 1'b0;
      r         <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
      sub_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.IN_VALID) begin
            op_a  <= bus.A;
            op_b  <= bus.B;
            cy    <= accept_carry;
            idx   <= '0;
            state <= RUN;
`ifdef MWADD_SUB_EN
            sub_q <= bus.SUB;
`else
            sub_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          r[32'(idx) * word_width +: word_width] <= sum;
          cy <= co;
          if (idx == LAST_IDX) begin
            c_out     <= co;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        HOLD: begin
          if (bus.OUT_READY) begin
            out_valid <= 1'b0;
            // Completing and accepting on the same edge avoids an idle bubble.
            if (bus.IN_VALID) begin
              op_a  <= bus.A;
              op_b  <= bus.B;
              cy    <= accept_carry;
              idx   <= '0;
              state <= RUN;
`ifdef MWADD_SUB_EN
              sub_q <= bus.SUB;
`else
              sub_q <= 1'b0;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed self-checking bench for multiword_adder_sequencer (8-bit words x 4).
module tb_multiword_adder_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multiword_adder_sequencer_if #(.word_width(8), .word_count(4)) bus ();

  multiword_adder_sequencer #(
    .cascade_size(4),
    .word_width  (8),
    .word_count  (4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operand set from IDLE; returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.C_IN     = ci;
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    bus.IN_VALID = 1'b0;
  endtask

  // Count negedges until OUT_VALID, bounded.
  task automatic wait_result(output int n);
    n = 0;
    while (bus.OUT_VALID !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.OUT_VALID); end
    checks++; if (bus.R !== 32'h0) begin errors++; $display("FAIL reset_r got %h exp 0", bus.R); end
    checks++; if (bus.C_OUT !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b exp 0", bus.C_OUT); end
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.IN_READY); end
  endtask

  task automatic test_basic_add();
    int n;
    start_op(32'h000000FF, 32'h00000001, 1'b0);
    checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL run_in_ready got %b exp 0", bus.IN_READY); end
    wait_result(n);
    checks++; if (n != 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", n); end
    checks++; if (bus.R !== 32'h00000100) begin errors++; $display("FAIL basic_r got %h exp 00000100", bus.R); end
    checks++; if (bus.C_OUT !== 1'b0) begin errors++; $display("FAIL basic_c_out got %b exp 0", bus.C_OUT); end
    consume();
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got %b exp 0", bus.OUT_VALID); end
  endtask

  task automatic test_wrap();
    int n;
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_result(n);
    checks++; if (bus.R !== 32'h00000000) begin errors++; $display("FAIL wrap_r got %h exp 00000000", bus.R); end
    checks++; if (bus.C_OUT !== 1'b1) begin errors++; $display("FAIL wrap_c_out got %b exp 1", bus.C_OUT); end
    consume();
  endtask

  task automatic test_carry_in();
    int n;
    start_op(32'h00000000, 32'h00000000, 1'b1);
    wait_result(n);
    checks++; if (bus.R !== 32'h00000001) begin errors++; $display("FAIL cin_r got %h exp 00000001", bus.R); end
    checks++; if (bus.C_OUT !== 1'b0) begin errors++; $display("FAIL cin_c_out got %b exp 0", bus.C_OUT); end
    consume();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(32'h00000001, 32'h00000002, 1'b0);
    wait_result(n);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b exp 1", i, bus.OUT_VALID); end
      checks++; if (bus.R !== 32'h00000003) begin errors++; $display("FAIL hold_r cyc %0d got %h exp 00000003", i, bus.R); end
      checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, bus.IN_READY); end
    end
    bus.OUT_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.A         = 32'h12345678;
    bus.B         = 32'h11111111;
    bus.C_IN      = 1'b0;
    #1;
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", bus.IN_READY); end
    @(negedge clk);
    bus.OUT_READY = 1'b0;
    bus.IN_VALID  = 1'b0;
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b exp 0", bus.OUT_VALID); end
    wait_result(n);
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", n); end
    checks++; if (bus.R !== 32'h23456789) begin errors++; $display("FAIL b2b_r got %h exp 23456789", bus.R); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int  n;
    logic seen;
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", bus.OUT_VALID); end
    checks++; if (bus.R !== 32'h0) begin errors++; $display("FAIL midrst_r got %h exp 0", bus.R); end
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus.IN_READY); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.OUT_VALID !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_ghost_result got %b exp 0", seen); end
    start_op(32'h00000010, 32'h00000020, 1'b0);
    wait_result(n);
    checks++; if (bus.R !== 32'h00000030) begin errors++; $display("FAIL midrst_next_r got %h exp 00000030", bus.R); end
    consume();
  endtask

  task automatic test_ignore_in_valid();
    int n;
    @(negedge clk);
    bus.A        = 32'h01020304;
    bus.B        = 32'h10203040;
    bus.C_IN     = 1'b1;
    bus.IN_VALID = 1'b1;
    @(negedge clk);
    bus.A    = 32'hFFFFFFFF;
    bus.B    = 32'hFFFFFFFF;
    bus.C_IN = 1'b0;
    checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL ignore_in_ready got %b exp 0", bus.IN_READY); end
    n = 0;
    while (bus.OUT_VALID !== 1'b1 && n < 40) begin
      @(negedge clk);
      bus.A = bus.A ^ 32'h5A5A5A5A;
      n++;
    end
    bus.IN_VALID = 1'b0;
    checks++; if (bus.R !== 32'h11223345) begin errors++; $display("FAIL ignore_r got %h exp 11223345", bus.R); end
    checks++; if (bus.C_OUT !== 1'b0) begin errors++; $display("FAIL ignore_c_out got %b exp 0", bus.C_OUT); end
    consume();
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_sub();
    int n;
    bus.SUB = 1'b1;
    start_op(32'h00000005, 32'h00000007, 1'b0);
    wait_result(n);
    checks++; if (bus.R !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_neg_r got %h exp fffffffe", bus.R); end
    checks++; if (bus.C_OUT !== 1'b0) begin errors++; $display("FAIL sub_neg_c_out got %b exp 0", bus.C_OUT); end
    consume();
    start_op(32'h00000007, 32'h00000005, 1'b1);
    wait_result(n);
    checks++; if (bus.R !== 32'h00000002) begin errors++; $display("FAIL sub_pos_r got %h exp 00000002", bus.R); end
    checks++; if (bus.C_OUT !== 1'b1) begin errors++; $display("FAIL sub_pos_c_out got %b exp 1", bus.C_OUT); end
    consume();
    bus.SUB = 1'b0;
  endtask
`endif

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.C_IN      = 1'b0;
`ifdef MWADD_SUB_EN
    bus.SUB       = 1'b0;
`endif
    test_reset();
    test_basic_add();
    test_wrap();
    test_carry_in();
    test_back_to_back();
    test_reset_mid_run();
    test_ignore_in_valid();
`ifdef MWADD_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
